// File: rtl/load_store_unit_if.sv
// Data-memory port of the load/store unit: single-word request/acknowledge bus.
// The LSU is the master; the data memory (or its model) is the slave.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [31:0]           dm_wdata;
  logic [31:0]           dm_rdata;
  logic                  dm_ack;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_rdata, dm_ack
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_rdata, dm_ack
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory stage: turns an ALU effective address plus load/store opcode into one
// data-memory transaction, with alignment/overflow and ack-timeout faulting.
module load_store_unit #(
  parameter int TIMEOUT    = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable_mem,
  input  logic [5:0]                opcode,
  input  logic [7:0]                sub_op_ls,
  input  logic [31:0]               alu_result,
  input  logic                      alu_overflow,
  input  logic [31:0]               store_data,
  load_store_unit_if.master         dm,
  output logic [31:0]               load_data,
  output logic                      load_valid,
  output logic                      mem_done,
  output logic                      mem_fault,
  output logic                      mem_busy
);

  // Opcode encodings shared with the decoder's def_op.v
  localparam logic [5:0] OP_LWI   = 6'h23;
  localparam logic [5:0] OP_SWI   = 6'h2B;
  localparam logic [5:0] OP_TY_LS = 6'h1C;
  localparam logic [7:0] SUB_LW   = 8'h01;
  localparam logic [7:0] SUB_SW   = 8'h02;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [7:0]            r_cnt, w_cntNext;
  logic                  r_fault, w_faultNext;
  logic                  r_isLoad, w_isLoadNext;
  logic                  w_start, w_capture, w_loadValidNext;
  logic                  w_isLoadOp, w_isStoreOp, w_badAddr;
  logic                  r_dm_req, r_dm_we;
  logic [ADDR_WIDTH-1:0] r_dm_addr;
  logic [31:0]           r_dm_wdata, r_load_data;
  logic                  r_load_valid, r_mem_done, r_mem_fault, r_mem_busy;

  assign w_isLoadOp  = (opcode == OP_LWI) || ((opcode == OP_TY_LS) && (sub_op_ls == SUB_LW));
  assign w_isStoreOp = (opcode == OP_SWI) || ((opcode == OP_TY_LS) && (sub_op_ls == SUB_SW));
  assign w_badAddr   = alu_overflow || (alu_result[1:0] != 2'b00);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 8'd0;
      r_fault  <= 1'b0;
      r_isLoad <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= w_cntNext;
      r_fault  <= w_faultNext;
      r_isLoad <= w_isLoadNext;
    end
  end

  // An ack is checked before the timeout so a last-cycle ack still succeeds
  always_comb begin
    w_next          = r_state;
    w_cntNext       = r_cnt;
    w_faultNext     = r_fault;
    w_isLoadNext    = r_isLoad;
    w_start         = 1'b0;
    w_capture       = 1'b0;
    w_loadValidNext = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable_mem) begin
          w_cntNext    = 8'd0;
          w_isLoadNext = w_isLoadOp;
          if (!w_isLoadOp && !w_isStoreOp) begin
            w_next      = S_DONE;
            w_faultNext = 1'b0;
          end else if (w_badAddr) begin
            w_next      = S_DONE;
            w_faultNext = 1'b1;
          end else begin
            w_next      = S_REQ;
            w_faultNext = 1'b0;
            w_start     = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (dm.dm_ack) begin
          w_next          = S_DONE;
          w_capture       = r_isLoad;
          w_loadValidNext = r_isLoad;
        end else if (r_cnt == 8'(TIMEOUT - 1)) begin
          w_next      = S_DONE;
          w_faultNext = 1'b1;
        end else begin
          w_cntNext = r_cnt + 8'd1;
        end
      end
      S_DONE: begin
        w_next      = S_IDLE;
        w_cntNext   = 8'd0;
        w_faultNext = 1'b0;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Every output is a flop fed from the next-state decode
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dm_req     <= 1'b0;
      r_dm_we      <= 1'b0;
      r_dm_addr    <= '0;
      r_dm_wdata   <= 32'd0;
      r_load_data  <= 32'd0;
      r_load_valid <= 1'b0;
      r_mem_done   <= 1'b0;
      r_mem_fault  <= 1'b0;
      r_mem_busy   <= 1'b0;
    end else begin
      r_dm_req     <= (w_next == S_REQ);
      r_load_valid <= w_loadValidNext;
      r_mem_done   <= (w_next == S_DONE);
      r_mem_fault  <= (w_next == S_DONE) && w_faultNext;
      r_mem_busy   <= (w_next != S_IDLE);
      if (w_start) begin
        r_dm_addr <= ADDR_WIDTH'(alu_result);
        r_dm_we   <= w_isStoreOp;
        if (w_isStoreOp) begin
          r_dm_wdata <= store_data;
        end
      end
      if (w_capture) begin
        r_load_data <= dm.dm_rdata;
      end
    end
  end

  assign dm.dm_req   = r_dm_req;
  assign dm.dm_we    = r_dm_we;
  assign dm.dm_addr  = r_dm_addr;
  assign dm.dm_wdata = r_dm_wdata;
  assign load_data   = r_load_data;
  assign load_valid  = r_load_valid;
  assign mem_done    = r_mem_done;
  assign mem_fault   = r_mem_fault;
  assign mem_busy    = r_mem_busy;

endmodule

// File: tb/tb_load_store_unit.sv
// Table-driven bench for load_store_unit: each vector is one memory-stage
// transaction observed over a fixed cycle window, plus reset sequences.
module tb_load_store_unit;

  localparam int TIMEOUT    = 4;
  localparam int ADDR_WIDTH = 32;
  localparam int WINDOW     = 12;

  localparam logic [5:0] OP_LWI   = 6'h23;
  localparam logic [5:0] OP_SWI   = 6'h2B;
  localparam logic [5:0] OP_TY_LS = 6'h1C;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [7:0] SUB_LW   = 8'h01;
  localparam logic [7:0] SUB_SW   = 8'h02;

  typedef struct {
    logic [5:0]  op;
    logic [7:0]  sub;
    logic [31:0] addr;
    logic        ovf;
    logic [31:0] wdata;
    int          ackCycle;
    logic [31:0] rdata;
    logic        secondEn;
    int          expReqCycles;
    logic        expWe;
    logic [31:0] expAddr;
    logic [31:0] expWdata;
    int          expDoneCycle;
    logic        expFault;
    logic        expLv;
    logic [31:0] expLd;
  } vec_t;

  logic        clock;
  logic        reset;
  logic        enable_mem;
  logic [5:0]  opcode;
  logic [7:0]  sub_op_ls;
  logic [31:0] alu_result;
  logic        alu_overflow;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        load_valid;
  logic        mem_done;
  logic        mem_fault;
  logic        mem_busy;

  int checks = 0;
  int errors = 0;
  vec_t vecs[13];

  load_store_unit_if #(.ADDR_WIDTH(ADDR_WIDTH)) dmBus ();

  load_store_unit #(.TIMEOUT(TIMEOUT), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable_mem   (enable_mem),
    .opcode       (opcode),
    .sub_op_ls    (sub_op_ls),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .store_data   (store_data),
    .dm           (dmBus),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .mem_done     (mem_done),
    .mem_fault    (mem_fault),
    .mem_busy     (mem_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    enable_mem   = 1'b1;
    opcode       = v.op;
    sub_op_ls    = v.sub;
    alu_result   = v.addr;
    alu_overflow = v.ovf;
    store_data   = v.wdata;
    dmBus.dm_ack = 1'b0;
  endtask

  // Cycle 0 carries enable_mem; cycles 1..WINDOW are observed at the falling edge
  task automatic runVector(input int idx);
    vec_t v;
    int reqCycles, doneCycle, doneCount;
    logic sawWe, sawFault, sawLv;
    logic [31:0] sawAddr, sawWdata, sawLd;
    v = vecs[idx];
    reqCycles = 0; doneCycle = -1; doneCount = 0;
    sawWe = 1'b0; sawFault = 1'b0; sawLv = 1'b0;
    sawAddr = 32'd0; sawWdata = 32'd0; sawLd = 32'd0;
    @(posedge clock); #1;
    applyStimulus(v);
    for (int c = 1; c <= WINDOW; c++) begin
      @(posedge clock); #1;
      enable_mem = v.secondEn && (c == 1);
      if (v.secondEn && c == 1) opcode = OP_ADDI;
      dmBus.dm_ack   = (v.ackCycle == c);
      dmBus.dm_rdata = dmBus.dm_ack ? v.rdata : (32'hCAFE_0000 | 32'(c));
      @(negedge clock);
      if (c == 1) checkOutput($sformatf("v%0d_busy", idx), 32'(mem_busy), 32'd1);
      if (dmBus.dm_req) begin
        if (reqCycles == 0) begin
          sawWe = dmBus.dm_we; sawAddr = dmBus.dm_addr; sawWdata = dmBus.dm_wdata;
        end
        reqCycles++;
      end
      if (mem_done) begin
        if (doneCount == 0) begin
          doneCycle = c; sawFault = mem_fault; sawLv = load_valid; sawLd = load_data;
        end
        doneCount++;
      end
    end
    dmBus.dm_ack = 1'b0;
    checkOutput($sformatf("v%0d_reqCycles", idx), 32'(reqCycles), 32'(v.expReqCycles));
    checkOutput($sformatf("v%0d_doneCycle", idx), 32'(doneCycle), 32'(v.expDoneCycle));
    checkOutput($sformatf("v%0d_doneCount", idx), 32'(doneCount), 32'd1);
    checkOutput($sformatf("v%0d_fault", idx), 32'(sawFault), 32'(v.expFault));
    checkOutput($sformatf("v%0d_loadValid", idx), 32'(sawLv), 32'(v.expLv));
    checkOutput($sformatf("v%0d_loadData", idx), sawLd, v.expLd);
    if (v.expReqCycles > 0) begin
      checkOutput($sformatf("v%0d_we", idx), 32'(sawWe), 32'(v.expWe));
      checkOutput($sformatf("v%0d_addr", idx), sawAddr, v.expAddr);
      if (v.expWe) checkOutput($sformatf("v%0d_wdata", idx), sawWdata, v.expWdata);
    end
  endtask

  initial begin
    // op, sub, addr, ovf, wdata, ackCycle, rdata, secondEn, reqCycles, we, addr, wdata, doneCycle, fault, lv, ld
    vecs[0]  = '{OP_LWI,   8'h00,  32'h10,  1'b0, 32'h0,         3, 32'hDEAD_BEEF, 1'b0, 3, 1'b0, 32'h10,  32'h0,         4, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[1]  = '{OP_TY_LS, SUB_SW, 32'h100, 1'b0, 32'h1234_5678, 1, 32'h0,         1'b0, 1, 1'b1, 32'h100, 32'h1234_5678, 2, 1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{OP_LWI,   8'h00,  32'h12,  1'b0, 32'h0,         0, 32'h0,         1'b0, 0, 1'b0, 32'h0,   32'h0,         1, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vecs[3]  = '{OP_LWI,   8'h00,  32'h20,  1'b1, 32'h0,         0, 32'h0,         1'b0, 0, 1'b0, 32'h0,   32'h0,         1, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vecs[4]  = '{OP_SWI,   8'h00,  32'h40,  1'b0, 32'hA5A5_A5A5, 0, 32'h0,         1'b0, 4, 1'b1, 32'h40,  32'hA5A5_A5A5, 5, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vecs[5]  = '{OP_ADDI,  8'h00,  32'h40,  1'b0, 32'h0,         0, 32'h0,         1'b0, 0, 1'b0, 32'h0,   32'h0,         1, 1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[6]  = '{OP_TY_LS, 8'h07,  32'h40,  1'b0, 32'h0,         0, 32'h0,         1'b0, 0, 1'b0, 32'h0,   32'h0,         1, 1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[7]  = '{OP_TY_LS, SUB_LW, 32'h44,  1'b0, 32'h0,         4, 32'h0BAD_F00D, 1'b0, 4, 1'b0, 32'h44,  32'h0,         5, 1'b0, 1'b1, 32'h0BAD_F00D};
    vecs[8]  = '{OP_LWI,   8'h00,  32'h48,  1'b0, 32'h0,         0, 32'h0,         1'b0, 4, 1'b0, 32'h48,  32'h0,         5, 1'b1, 1'b0, 32'h0BAD_F00D};
    vecs[9]  = '{OP_LWI,   8'h00,  32'h80,  1'b0, 32'h0,         3, 32'h1122_3344, 1'b1, 3, 1'b0, 32'h80,  32'h0,         4, 1'b0, 1'b1, 32'h1122_3344};
    vecs[10] = '{OP_SWI,   8'h00,  32'h41,  1'b0, 32'h9999_9999, 0, 32'h0,         1'b0, 0, 1'b0, 32'h0,   32'h0,         1, 1'b1, 1'b0, 32'h1122_3344};
    vecs[11] = '{OP_ADDI,  8'h00,  32'h0,   1'b0, 32'h0,         1, 32'h7777_7777, 1'b0, 0, 1'b0, 32'h0,   32'h0,         1, 1'b0, 1'b0, 32'h1122_3344};
    vecs[12] = '{OP_LWI,   8'h00,  32'h94,  1'b0, 32'h0,         1, 32'h55AA_55AA, 1'b0, 1, 1'b0, 32'h94,  32'h0,         2, 1'b0, 1'b1, 32'h55AA_55AA};

    reset = 1'b0; enable_mem = 1'b0; opcode = 6'd0; sub_op_ls = 8'd0;
    alu_result = 32'd0; alu_overflow = 1'b0; store_data = 32'd0;
    dmBus.dm_ack = 1'b0; dmBus.dm_rdata = 32'd0;
    #12;
    checkOutput("rst_dm_req", 32'(dmBus.dm_req), 32'd0);
    checkOutput("rst_dm_we", 32'(dmBus.dm_we), 32'd0);
    checkOutput("rst_dm_addr", dmBus.dm_addr, 32'd0);
    checkOutput("rst_dm_wdata", dmBus.dm_wdata, 32'd0);
    checkOutput("rst_load_data", load_data, 32'd0);
    checkOutput("rst_flags", {28'd0, load_valid, mem_done, mem_fault, mem_busy}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) runVector(i);

    // Reset in the middle of a pending load must drop the bus at once, no completion
    begin
      vec_t v;
      int doneSeen;
      v = vecs[8];
      v.addr = 32'h90;
      @(posedge clock); #1;
      applyStimulus(v);
      @(posedge clock); #1;
      enable_mem = 1'b0;
      @(negedge clock);
      checkOutput("rs_req_before", 32'(dmBus.dm_req), 32'd1);
      @(posedge clock); #1;
      reset = 1'b0;
      #1;
      checkOutput("rs_req_dropped", 32'(dmBus.dm_req), 32'd0);
      checkOutput("rs_busy_dropped", 32'(mem_busy), 32'd0);
      checkOutput("rs_load_data", load_data, 32'd0);
      doneSeen = 0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clock);
        if (mem_done) doneSeen++;
      end
      checkOutput("rs_no_done", 32'(doneSeen), 32'd0);
      @(posedge clock); #1;
      reset = 1'b1;
    end
    runVector(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage of the core; sits directly downstream of the ALU.
- Takes the ALU-computed effective address (alu_result/alu_overflow) plus the decoded load/store opcode.
- Runs a single-word request/acknowledge transaction on the data-memory port and returns load data for writeback.
- Signals completion or fault to the controller so it can advance to writeback.

Parameters:
- TIMEOUT, 16: max cycles dm_req stays high without dm_ack before the access is aborted as a fault. Range 1..255.
- ADDR_WIDTH, 32: width of dm_addr. Low ADDR_WIDTH bits of alu_result are used.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable_mem  in  1  one-cycle start strobe from the controller.
- opcode  in  6  instruction opcode (def_op.v encodings).
- sub_op_ls  in  8  load/store sub-opcode, valid when opcode==TY_LS.
- alu_result  in  32  effective address from the ALU.
- alu_overflow  in  1  address overflow flag from the ALU.
- store_data  in  32  rt register value for stores.
- dm_req  out  1  data-memory request.
- dm_we  out  1  1=write, 0=read; valid while dm_req is high.
- dm_addr  out  ADDR_WIDTH  word-aligned byte address.
- dm_wdata  out  32  store data.
- dm_rdata  in  32  read data; valid in the cycle dm_ack is high.
- dm_ack  in  1  memory acknowledge.
- load_data  out  32  captured load result.
- load_valid  out  1  one-cycle pulse; load_data is valid.
- mem_done  out  1  one-cycle completion pulse.
- mem_fault  out  1  one-cycle pulse coincident with mem_done; access aborted.
- mem_busy  out  1  high while a transaction is in flight (state != IDLE).

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE.
  - All outputs = 0, including load_data, dm_addr, dm_wdata.
  - Timeout counter = 0.
  - Reset asserted mid-transaction drops dm_req immediately, and no mem_done is issued.
- Op classes, decoded when enable_mem=1 in IDLE:
  - LOAD = LWI, or TY_LS with sub_op_ls==LW.
  - STORE = SWI, or TY_LS with sub_op_ls==SW.
  - Anything else = NONMEM.
- State IDLE:
  - NONMEM: go to DONE, no dm_req, no fault.
  - LOAD/STORE with alu_overflow=1 or alu_result[1:0]!=0: go to DONE with a pending fault, no dm_req.
  - Otherwise register dm_addr=alu_result, dm_wdata=store_data (stores only; loads keep the previous value), dm_we=STORE. Assert dm_req and go to REQ. dm_req is high in the cycle after enable_mem.
- State REQ:
  - dm_req, dm_we, dm_addr and dm_wdata are held stable.
  - The counter increments each cycle dm_ack=0.
  - dm_ack=1: deassert dm_req next cycle. For LOAD, capture dm_rdata into load_data. Go to DONE.
  - Counter reaches TIMEOUT with no ack: deassert dm_req, set a pending fault, go to DONE. load_data is unchanged.
  - An ack in the same cycle the counter reaches TIMEOUT counts as success.
- State DONE (exactly one cycle):
  - mem_done=1.
  - load_valid=1 only for a successful LOAD.
  - mem_fault=1 if a fault is pending.
  - Next state IDLE. The counter and pending fault clear.
- Registered outputs: all outputs are registered; dm_req drives no combinational path from dm_ack.
- Latency:
  - enable_mem at cycle 0, dm_ack first high at cycle k (k>=1) → mem_done at cycle k+1.
  - Zero-wait memory (ack at cycle 1) → mem_done at cycle 2.
  - NONMEM or alignment fault → mem_done at cycle 1.
- mem_busy:
  - mem_busy = (state != IDLE).
  - enable_mem while busy is ignored and not queued.
- Stray handling:
  - dm_ack outside REQ is ignored.
  - Unknown sub_op_ls under TY_LS is treated as NONMEM.
- load_data holds its value until the next successful load.

Test Plan:
- LWI, alu_result=0x0000_0010; memory acks at cycle 3 with dm_rdata=0xDEAD_BEEF → dm_req high cycles 1-3, dm_we=0, dm_addr=0x10; mem_done and load_valid at cycle 4; load_data=0xDEAD_BEEF; mem_fault=0.
- TY_LS/SW, alu_result=0x0000_0100, store_data=0x1234_5678, zero-wait ack → dm_we=1, dm_wdata=0x1234_5678 at cycle 1; mem_done at cycle 2; load_valid=0.
- LWI with alu_result=0x0000_0012, or with alu_overflow=1 → no dm_req; mem_done and mem_fault at cycle 1; load_data unchanged.
- SWI, TIMEOUT=4, dm_ack never asserted → dm_req high cycles 1-4, low at 5; mem_done and mem_fault at cycle 5.
- ADDI with enable_mem → mem_done at cycle 1, no dm_req. A second enable_mem during an in-flight LWI is ignored, and only one mem_done is seen.
- reset driven low at cycle 2 of a pending LWI → dm_req and mem_busy go 0 immediately, no mem_done. After release, a new LWI completes normally.
